// File: rtl/riscv_pkg.sv
// Shared decode/execute definitions.
//   ctrl_t        packed control bundle; reg_write is the MSB and funct3 the LSBs
//   CTRL_W        width of ctrl_t
//   IMM_*         immSrc encodings used by the immediate sign-extender
//   RESULT_*      result_src encodings
//   ctrl_is_bubble  true when a bundle has no architectural side effect
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 14;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic [2:0] funct3;
  } ctrl_t;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  // A bubble carries an all-zero bundle, so none of the side-effect bits can be set.
  function automatic logic ctrl_is_bubble(input ctrl_t c);
    return (c == '0);
  endfunction

endpackage

// File: rtl/id_ex_reg_pipe_field.sv
// pipe_field: width-parameterised pipeline flop.
//   clk  rising-edge clock
//   clr  synchronous clear, wins over en
//   en   load enable (low = hold)
//   d    next value
//   q    registered value
module pipe_field #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (clr)     r_q <= '0;
    else if (en) r_q <= d;
  end

  assign q = r_q;

endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: decode-to-execute pipeline register.
// Captures decode-stage operands, indices, PCs and control, presenting them to
// execute one cycle later. Supports stall (hold), flush (bubble) and a valid bit.
//   clk, rst                 clock, synchronous active-high reset
//   stall, flush             hazard controls; flush beats stall
//   valid_d ... ctrl_d       decode-stage inputs
//   valid_e ... ctrl_e       registered copies for execute
//   bubble_cnt               bubbles loaded since reset, saturating
// Optional: ID_EX_INSTR_TRACE_EN adds instr_d -> instr_e and a per-instruction
// sequence number seq_e taken from an internal wrapping counter.
module id_ex_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   pc_plus4_d,
  input  logic [XLEN-1:0]   rd1_d,
  input  logic [XLEN-1:0]   rd2_d,
  input  logic [XLEN-1:0]   imm_ext_d,
  input  logic [4:0]        rs1_d,
  input  logic [4:0]        rs2_d,
  input  logic [4:0]        rd_d,
  input  logic [CTRL_W-1:0] ctrl_d,
`ifdef ID_EX_INSTR_TRACE_EN
  input  logic [31:0]       instr_d,
  output logic [31:0]       instr_e,
  output logic [31:0]       seq_e,
`endif
  output logic              valid_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   pc_plus4_e,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [XLEN-1:0]   imm_ext_e,
  output logic [4:0]        rs1_e,
  output logic [4:0]        rs2_e,
  output logic [4:0]        rd_e,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [15:0]       bubble_cnt
);

  import riscv_pkg::*;

  logic w_en;        // load enable for every field
  logic w_clr_data;  // zero data/index fields
  logic w_load_bub;  // this edge loads a bubble (outside reset)
  logic w_clr_bub;   // zero valid/control

  assign w_en       = !stall;
  assign w_clr_data = rst | flush;
  // A stalled slot holds even when valid_d is low; only a real load of an
  // empty decode slot turns into a bubble.
  assign w_load_bub = flush | (!stall & !valid_d);
  assign w_clr_bub  = rst | w_load_bub;

  pipe_field #(.W(1))      u_valid  (.clk(clk), .clr(w_clr_bub),  .en(w_en), .d(valid_d),    .q(valid_e));
  pipe_field #(.W(CTRL_W)) u_ctrl   (.clk(clk), .clr(w_clr_bub),  .en(w_en), .d(ctrl_d),     .q(ctrl_e));
  pipe_field #(.W(XLEN))   u_pc     (.clk(clk), .clr(w_clr_data), .en(w_en), .d(pc_d),       .q(pc_e));
  pipe_field #(.W(XLEN))   u_pc4    (.clk(clk), .clr(w_clr_data), .en(w_en), .d(pc_plus4_d), .q(pc_plus4_e));
  pipe_field #(.W(XLEN))   u_rd1    (.clk(clk), .clr(w_clr_data), .en(w_en), .d(rd1_d),      .q(rd1_e));
  pipe_field #(.W(XLEN))   u_rd2    (.clk(clk), .clr(w_clr_data), .en(w_en), .d(rd2_d),      .q(rd2_e));
  pipe_field #(.W(XLEN))   u_imm    (.clk(clk), .clr(w_clr_data), .en(w_en), .d(imm_ext_d),  .q(imm_ext_e));
  pipe_field #(.W(5))      u_rs1    (.clk(clk), .clr(w_clr_data), .en(w_en), .d(rs1_d),      .q(rs1_e));
  pipe_field #(.W(5))      u_rs2    (.clk(clk), .clr(w_clr_data), .en(w_en), .d(rs2_d),      .q(rs2_e));
  pipe_field #(.W(5))      u_rd     (.clk(clk), .clr(w_clr_data), .en(w_en), .d(rd_d),       .q(rd_e));

  // Saturating bubble counter.
  logic [15:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst)                                      r_bubble_cnt <= '0;
    else if (w_load_bub && r_bubble_cnt != 16'hFFFF) r_bubble_cnt <= r_bubble_cnt + 16'd1;
  end

  assign bubble_cnt = r_bubble_cnt;

`ifdef ID_EX_INSTR_TRACE_EN
  // Sequence numbers are handed out only to instructions actually entering execute.
  logic        w_cap_valid;
  logic [31:0] r_seq_ctr;

  assign w_cap_valid = valid_d & !flush & !stall;

  always_ff @(posedge clk) begin
    if (rst)              r_seq_ctr <= '0;
    else if (w_cap_valid) r_seq_ctr <= r_seq_ctr + 32'd1;
  end

  pipe_field #(.W(32)) u_instr (.clk(clk), .clr(w_clr_data), .en(w_en), .d(instr_d),   .q(instr_e));
  pipe_field #(.W(32)) u_seq   (.clk(clk), .clr(w_clr_bub),  .en(w_en), .d(r_seq_ctr), .q(seq_e));
`endif

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Decode-to-execute pipeline register, directly downstream of the immediate sign-extender.
- Captures the extended immediate, register-file read data, register indices, PC values and decoded control bundle at the end of decode, then presents them to execute one cycle later.
- Implements stall (hold), flush (bubble insertion) and a valid bit so hazard logic can freeze or squash the execute stage.

Parameters:
- XLEN, 32, datapath width of PC, operand and immediate fields.
- CTRL_W, 14, width of packed control bundle (ctrl_t in package).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- stall  in  1  hold all outputs at current value
- flush  in  1  squash: load a bubble next edge
- valid_d  in  1  decode slot holds a real instruction
- pc_d  in  XLEN  PC of decode instruction
- pc_plus4_d  in  XLEN  pc_d+4
- rd1_d  in  XLEN  rs1 read data
- rd2_d  in  XLEN  rs2 read data
- imm_ext_d  in  XLEN  sign-extended immediate from decode
- rs1_d  in  5  source register 1 index
- rs2_d  in  5  source register 2 index
- rd_d  in  5  destination register index
- ctrl_d  in  CTRL_W  control bundle: reg_write, result_src[1:0], mem_write, jump, branch, alu_ctrl[3:0], alu_src, funct3[2:0]
- valid_e, pc_e, pc_plus4_e, rd1_e, rd2_e, imm_ext_e, rs1_e, rs2_e, rd_e, ctrl_e  out  (widths as _d counterparts)  registered copies for execute
- bubble_cnt  out  16  count of bubbles loaded since reset

Behaviour:
- Reset: on rising clk with rst=1, every output is 0, valid_e=0, bubble_cnt=0. Reset overrides stall and flush.
- Priority per edge: rst > flush > stall > normal capture.
- Normal (no rst/flush/stall): all _e <= _d; valid_e <= valid_d. Latency 1 cycle.
- valid_d=0 on normal capture: data fields captured, but ctrl_e <= 0 and valid_e <= 0. Counts as a bubble.
- flush=1: valid_e <= 0, ctrl_e <= 0, all data/index fields <= 0. Counts as a bubble.
- flush=1 with stall=1 in the same cycle: flush wins, and the bubble is loaded.
- stall=1 (no flush): every output holds, including valid_e. bubble_cnt does not change.
- Bubble definition: ctrl_e all-zero, so reg_write=0, mem_write=0, jump=0 and branch=0. This guarantees no architectural side effect downstream.
- bubble_cnt: +1 on each edge that loads a bubble; saturates at 16'hFFFF and does not wrap.
- Immediate and data fields are opaque: no arithmetic, no re-extension; all bits are passed unchanged.
- No combinational path from any input to any output.

Optional Feature:
- Macro: ID_EX_INSTR_TRACE_EN.
- Defined: adds input instr_d[31:0], outputs instr_e[31:0] and seq_e[31:0], and an internal 32-bit sequence counter.
  - instr_e follows the same capture, hold and flush rules as the data fields; it is zeroed on flush.
  - The counter increments on each edge that captures valid_d=1 without flush or stall. It wraps at 2^32 to 0.
  - seq_e <= the counter value before the increment. It is zeroed on bubble and reset.
- Undefined: these ports and the counter are absent. All other behaviour is identical.

Decomposition:
- Shared package riscv_pkg holds:
  - ctrl_t packed struct (field order as listed under ctrl_d, reg_write MSB) and CTRL_W.
  - immSrc encoding constants IMM_I=3'b000, IMM_S=3'b001, IMM_B=3'b010, IMM_U=3'b011, IMM_J=3'b100.
  - RESULT_ALU/RESULT_MEM/RESULT_PC4 encodings.
- One natural sub-module, pipe_field: a width-parameterised flop with en (=!stall) and sync clear (=rst|flush).
  - It is instantiated per field. valid_e and ctrl_e also use the bubble clear for valid_d=0.
- bubble_cnt and the trace counter live in id_ex_reg.

Test Plan:
- Reset, then one normal capture:
  - Reset: assert rst 2 cycles with nonzero inputs -> all outputs 0, bubble_cnt=0.
  - Release rst, valid_d=1, imm_ext_d=32'hFFFFF800, pc_d=32'h100, rd_d=5, ctrl_d.reg_write=1 -> next cycle imm_ext_e=32'hFFFFF800, pc_e=32'h100, rd_e=5, valid_e=1.
- Stall: capture pc_d=32'h200, then stall=1 for 3 cycles while pc_d changes to 32'h204 -> pc_e stays 32'h200 and valid_e stays 1 throughout. bubble_cnt is unchanged.
- Flush: valid_e=1 with mem_write=1, then flush=1 -> next cycle valid_e=0, ctrl_e=0, imm_ext_e=0, bubble_cnt +1.
- Flush and stall together: flush=1 and stall=1 in the same cycle -> bubble loaded, not hold.
- valid_d=0 with ctrl_d=all-ones -> ctrl_e=0, valid_e=0, bubble_cnt +1.
- bubble_cnt saturation: force 65537 flushes -> bubble_cnt=16'hFFFF.
- Trace (ID_EX_INSTR_TRACE_EN): 3 valid captures with one stall between them, then a flush -> seq_e=0, 1, 2; stalled cycle holds; after flush seq_e=0 and instr_e=0. The next valid capture gives seq_e=3.
